// File: rtl/upc_seq.sv
// rtl/upc_seq.sv - micro-program sequencer with branch, hold and call/return stack
//
// Purpose: produces the next microcode ROM address each enabled cycle from a
// 3-bit sequencing opcode. It supports conditional jumps, hold, restart and a
// LIFO return stack with sticky overflow/underflow flags.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-low reset (clears upc, depth, ovf, unf)
//   en      in   advance enable; 0 freezes all state
//   op      in   sequencing opcode (INC/JMP/JT/JF/CALL/RET/HOLD/RESTART)
//   cond    in   branch condition for JT/JF
//   target  in   jump/call destination
//   upc     out  current micro-address (registered)
//   depth   out  occupied return-stack entries
//   full    out  depth == DEPTH
//   empty   out  depth == 0
//   ovf     out  sticky: CALL attempted while full
//   unf     out  sticky: RET attempted while empty
module upc_seq #(
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [2:0]    op,
  input  logic          cond,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] upc,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);

  localparam logic [2:0] OP_INC     = 3'b000;
  localparam logic [2:0] OP_JMP     = 3'b001;
  localparam logic [2:0] OP_JT      = 3'b010;
  localparam logic [2:0] OP_JF      = 3'b011;
  localparam logic [2:0] OP_CALL    = 3'b100;
  localparam logic [2:0] OP_RET     = 3'b101;
  localparam logic [2:0] OP_HOLD    = 3'b110;
  localparam logic [2:0] OP_RESTART = 3'b111;

  // Stack index width; a one-entry stack still needs a 1-bit index.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] r_upc;
  logic [DW-1:0] r_depth;
  logic          r_ovf;
  logic          r_unf;
  logic [AW-1:0] r_stack [DEPTH];

  logic [AW-1:0] w_inc;
  logic [AW-1:0] w_upc_nxt;
  logic [DW-1:0] w_depth_nxt;
  logic [DW-1:0] w_top;
  logic [IW-1:0] w_push_idx;
  logic [IW-1:0] w_pop_idx;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_set_ovf;
  logic          w_set_unf;

  // Wraps silently from all-ones to zero.
  assign w_inc      = r_upc + AW'(1);
  assign w_full     = (r_depth == DW'(DEPTH));
  assign w_empty    = (r_depth == '0);
  assign w_top      = r_depth - DW'(1);
  assign w_push_idx = r_depth[IW-1:0];
  assign w_pop_idx  = w_top[IW-1:0];

  always_comb begin
    w_upc_nxt   = r_upc;
    w_depth_nxt = r_depth;
    w_push      = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    case (op)
      OP_INC:  w_upc_nxt = w_inc;
      OP_JMP:  w_upc_nxt = target;
      OP_JT:   w_upc_nxt = cond ? target : w_inc;
      OP_JF:   w_upc_nxt = cond ? w_inc : target;
      OP_CALL: begin
        // A CALL on a full stack degrades to INC and latches the error.
        if (!w_full) begin
          w_push      = 1'b1;
          w_depth_nxt = r_depth + DW'(1);
          w_upc_nxt   = target;
        end else begin
          w_upc_nxt = w_inc;
          w_set_ovf = 1'b1;
        end
      end
      OP_RET: begin
        if (!w_empty) begin
          w_upc_nxt   = r_stack[w_pop_idx];
          w_depth_nxt = w_top;
        end else begin
          w_upc_nxt = w_inc;
          w_set_unf = 1'b1;
        end
      end
      OP_HOLD: w_upc_nxt = r_upc;
      OP_RESTART: begin
        w_upc_nxt   = '0;
        w_depth_nxt = '0;
      end
      default: w_upc_nxt = r_upc;
    endcase
  end

  // Stack storage is not reset; depth alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_upc   <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (en) begin
      r_upc   <= w_upc_nxt;
      r_depth <= w_depth_nxt;
      if (w_push) r_stack[w_push_idx] <= w_inc;
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
    end
  end

  assign upc   = r_upc;
  assign depth = r_depth;
  assign full  = w_full;
  assign empty = w_empty;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_upc_seq.sv
// tb/tb_upc_seq.sv - self-checking bench for upc_seq with scoreboard queue
module tb_upc_seq;

  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [2:0]    op;
  logic          cond;
  logic [AW-1:0] target;
  logic [AW-1:0] upc;
  logic [DW-1:0] depth;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          unf;

  always #5 clk = ~clk;

  upc_seq #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .op     (op),
    .cond   (cond),
    .target (target),
    .upc    (upc),
    .depth  (depth),
    .full   (full),
    .empty  (empty),
    .ovf    (ovf),
    .unf    (unf)
  );

  typedef struct {
    int upc;
    int depth;
    int full;
    int empty;
    int ovf;
    int unf;
  } exp_t;

  exp_t exp_q[$];

  int m_upc = 0;
  int m_stk[$];
  int m_ovf = 0;
  int m_unf = 0;
  int n_assert = 0;
  int n_fail = 0;
  int n_step = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s (step %0d): observed=%0d expected=%0d", tag, n_step, got, exp);
    end
  endtask

  // Drive one cycle, predict the result into the scoreboard, then pop and compare.
  task automatic step(input bit r, input bit e, input logic [2:0] o, input bit c, input int t);
    exp_t x;
    int   inc;
    @(negedge clk);
    reset  = r;
    en     = e;
    op     = o;
    cond   = c;
    target = t[AW-1:0];
    inc    = (m_upc + 1) % (1 << AW);
    if (!r) begin
      m_upc = 0;
      m_stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (e) begin
      case (o)
        3'd0: m_upc = inc;
        3'd1: m_upc = t;
        3'd2: m_upc = c ? t : inc;
        3'd3: m_upc = c ? inc : t;
        3'd4: begin
          if (m_stk.size() < DEPTH) begin
            m_stk.push_back(inc);
            m_upc = t;
          end else begin
            m_upc = inc;
            m_ovf = 1;
          end
        end
        3'd5: begin
          if (m_stk.size() > 0) m_upc = m_stk.pop_back();
          else begin
            m_upc = inc;
            m_unf = 1;
          end
        end
        3'd6: m_upc = m_upc;
        default: begin
          m_upc = 0;
          m_stk.delete();
        end
      endcase
    end
    x.upc   = m_upc;
    x.depth = m_stk.size();
    x.full  = (m_stk.size() == DEPTH) ? 1 : 0;
    x.empty = (m_stk.size() == 0) ? 1 : 0;
    x.ovf   = m_ovf;
    x.unf   = m_unf;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    n_step++;
    x = exp_q.pop_front();
    chk("upc", 32'(upc), x.upc);
    chk("depth", 32'(depth), x.depth);
    chk("full", 32'(full), x.full);
    chk("empty", 32'(empty), x.empty);
    chk("ovf", 32'(ovf), x.ovf);
    chk("unf", 32'(unf), x.unf);
  endtask

  initial begin
    reset  = 1'b0;
    en     = 1'b0;
    op     = 3'd0;
    cond   = 1'b0;
    target = '0;

    // 1. reset, INC with wrap, enable low
    step(0, 1, 3'd0, 0, 0);
    step(0, 1, 3'd0, 0, 0);
    chk("reset upc", 32'(upc), 0);
    chk("reset empty", 32'(empty), 1);
    for (int i = 0; i < 33; i++) begin
      step(1, 1, 3'd0, 0, 0);
      if (i == 30) chk("wrap top", 32'(upc), 31);
      if (i == 31) chk("wrap zero", 32'(upc), 0);
    end
    chk("inc end", 32'(upc), 1);
    for (int i = 0; i < 3; i++) step(1, 0, 3'd1, 1, 17);
    chk("en hold", 32'(upc), 1);

    // 2. branches
    step(1, 1, 3'd0, 0, 0);
    step(1, 1, 3'd0, 0, 0);
    step(1, 1, 3'd2, 1, 20);
    chk("jt taken", 32'(upc), 20);
    step(1, 1, 3'd2, 0, 9);
    chk("jt not", 32'(upc), 21);
    step(1, 1, 3'd3, 0, 9);
    chk("jf taken", 32'(upc), 9);
    step(1, 1, 3'd3, 1, 9);
    chk("jf not", 32'(upc), 10);
    step(1, 1, 3'd6, 0, 0);
    step(1, 1, 3'd6, 0, 0);
    chk("hold", 32'(upc), 10);

    // 3. nested call/return
    step(1, 1, 3'd7, 0, 0);
    step(1, 1, 3'd0, 0, 0);
    step(1, 1, 3'd0, 0, 0);
    step(1, 1, 3'd4, 0, 10);
    step(1, 1, 3'd0, 0, 0);
    step(1, 1, 3'd4, 0, 20);
    step(1, 1, 3'd0, 0, 0);
    step(1, 1, 3'd4, 0, 30);
    chk("nest depth", 32'(depth), 3);
    step(1, 1, 3'd5, 0, 0);
    chk("ret1", 32'(upc), 22);
    step(1, 1, 3'd5, 0, 0);
    chk("ret2", 32'(upc), 12);
    step(1, 1, 3'd5, 0, 0);
    chk("ret3", 32'(upc), 3);
    chk("ret empty", 32'(empty), 1);

    // 4. overflow
    step(1, 1, 3'd7, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 3'd4, 0, 8);
    chk("ovf full", 32'(full), 1);
    step(1, 1, 3'd4, 0, 8);
    chk("ovf upc", 32'(upc), 9);
    chk("ovf depth", 32'(depth), 4);
    chk("ovf set", 32'(ovf), 1);
    for (int i = 0; i < 4; i++) step(1, 1, 3'd5, 0, 0);
    chk("ovf sticky", 32'(ovf), 1);
    chk("ovf ret upc", 32'(upc), 1);

    // 5. underflow and edges
    step(1, 1, 3'd1, 0, 6);
    step(1, 1, 3'd5, 0, 0);
    chk("unf upc", 32'(upc), 7);
    chk("unf set", 32'(unf), 1);
    step(1, 1, 3'd1, 0, 31);
    step(1, 1, 3'd4, 0, 4);
    chk("call top", 32'(upc), 4);
    step(1, 1, 3'd5, 0, 0);
    chk("ret wrap", 32'(upc), 0);
    step(1, 1, 3'd4, 0, 5);
    step(1, 1, 3'd4, 0, 5);
    step(1, 1, 3'd7, 0, 0);
    chk("restart upc", 32'(upc), 0);
    chk("restart depth", 32'(depth), 0);
    chk("restart ovf", 32'(ovf), 1);

    // 6. reset priority mid-subroutine
    for (int i = 0; i < 3; i++) step(1, 1, 3'd4, 0, 12);
    step(0, 1, 3'd4, 0, 12);
    chk("rst upc", 32'(upc), 0);
    chk("rst depth", 32'(depth), 0);
    chk("rst ovf", 32'(ovf), 0);
    chk("rst unf", 32'(unf), 0);
    step(1, 1, 3'd5, 0, 0);
    chk("post rst upc", 32'(upc), 1);
    chk("post rst unf", 32'(unf), 1);

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
